// File: rtl/mips_multicycle.sv
// mips_multicycle: multicycle MIPS-I subset core; one ALU and register file are shared across FSM steps,
// with req/ack instruction and data ports. Define MIPS_EXT_ISA_EN to also decode bne/andi/ori/slti.
module mips_multicycle #(
  parameter int unsigned       ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [31:0]       dmem_wdata,
  input  logic              dmem_ack,
  input  logic [31:0]       dmem_rdata,
  output logic              retire,
  output logic              illegal
);

  // state    | meaning
  // FETCH    | imem request at PC; IR/PC+4 captured on ack
  // DECODE   | read rs/rt into A/B, branch target into ALUOut, dispatch (illegal retires here)
  // EXEC     | R-type ALU op
  // ALUWB    | rf[rd] <= ALUOut, retire
  // MEMADR   | ALUOut <= rs + sext(imm)
  // MEMRD    | dmem load request; MDR captured on ack
  // MEMWB    | rf[rt] <= MDR, retire
  // MEMWR    | dmem store request; retire on ack
  // ADDIEX   | immediate ALU op
  // ADDIWB   | rf[rt] <= ALUOut, retire
  // BRANCH   | conditional PC <= ALUOut, retire
  // JUMP     | PC <= pseudo-direct target, retire
  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_EXEC, S_ALUWB, S_MEMADR, S_MEMRD,
    S_MEMWB, S_MEMWR, S_ADDIEX, S_ADDIWB, S_BRANCH, S_JUMP
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
`ifdef MIPS_EXT_ISA_EN
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
`endif
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_SLT   = 6'h2A;

  state_t            state, state_nxt, dec_state;
  logic [ADDR_W-1:0] pc, br_tgt, jmp_tgt;
  logic [31:0]       ir, a_reg, b_reg, alu_out, mdr, alu_res;
  logic [31:0]       rf [32];

  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, wr_addr;
  logic [15:0] imm;
  logic [31:0] imm_sext, br_off, wr_data;
  logic        dec_ok, take, wr_en;
  logic        unused_shamt;

  assign opcode       = ir[31:26];
  assign rs           = ir[25:21];
  assign rt           = ir[20:16];
  assign rd           = ir[15:11];
  assign funct        = ir[5:0];
  assign imm          = ir[15:0];
  assign unused_shamt = ^ir[10:6];
  assign imm_sext     = {{16{imm[15]}}, imm};
  assign br_off       = {imm_sext[29:0], 2'b00};
  assign br_tgt       = pc + ADDR_W'($signed(br_off));
  // Keep PC bits above the 28-bit jump field; widths below 28 just truncate the target.
  assign jmp_tgt      = (pc & ~ADDR_W'(32'h0FFF_FFFF)) | ADDR_W'({ir[25:0], 2'b00});

`ifdef MIPS_EXT_ISA_EN
  logic [31:0] imm_zext;
  assign imm_zext = {16'h0000, imm};
  assign take     = (opcode == OP_BNE) ? (a_reg != b_reg) : (a_reg == b_reg);
`else
  assign take     = (a_reg == b_reg);
`endif

  assign imem_addr  = pc;
  assign dmem_addr  = ADDR_W'(alu_out);
  assign dmem_wdata = b_reg;

  always_comb begin
    dec_state = S_FETCH;
    dec_ok    = 1'b1;
    case (opcode)
      OP_RTYPE: begin
        if (funct inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT}) dec_state = S_EXEC;
        else dec_ok = 1'b0;
      end
      OP_LW, OP_SW: dec_state = S_MEMADR;
      OP_ADDI:      dec_state = S_ADDIEX;
      OP_BEQ:       dec_state = S_BRANCH;
      OP_J:         dec_state = S_JUMP;
`ifdef MIPS_EXT_ISA_EN
      OP_BNE:                    dec_state = S_BRANCH;
      OP_ANDI, OP_ORI, OP_SLTI:  dec_state = S_ADDIEX;
`endif
      default:      dec_ok = 1'b0;
    endcase
  end

  always_comb begin
    alu_res = '0;
    case (state)
      S_EXEC: begin
        case (funct)
          FN_ADD:  alu_res = a_reg + b_reg;
          FN_SUB:  alu_res = a_reg - b_reg;
          FN_AND:  alu_res = a_reg & b_reg;
          FN_OR:   alu_res = a_reg | b_reg;
          FN_SLT:  alu_res = {31'b0, $signed(a_reg) < $signed(b_reg)};
          default: alu_res = '0;
        endcase
      end
      S_MEMADR: alu_res = a_reg + imm_sext;
      S_ADDIEX: begin
        alu_res = a_reg + imm_sext;
`ifdef MIPS_EXT_ISA_EN
        case (opcode)
          OP_ANDI: alu_res = a_reg & imm_zext;
          OP_ORI:  alu_res = a_reg | imm_zext;
          OP_SLTI: alu_res = {31'b0, $signed(a_reg) < $signed(imm_sext)};
          default: ;
        endcase
`endif
      end
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    wr_en   = 1'b0;
    wr_addr = rt;
    wr_data = alu_out;
    case (state)
      S_ALUWB:  begin wr_en = 1'b1; wr_addr = rd; end
      S_MEMWB:  begin wr_en = 1'b1; wr_data = mdr; end
      S_ADDIWB: wr_en = 1'b1;
      default:  ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_FETCH;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    imem_req  = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    retire    = 1'b0;
    illegal   = 1'b0;
    case (state)
      S_FETCH: begin
        // The state register already sits in FETCH during reset; keep the request quiet then.
        imem_req = rst;
        if (imem_ack) state_nxt = S_DECODE;
      end
      S_DECODE: begin
        if (dec_ok) state_nxt = dec_state;
        else begin
          illegal   = 1'b1;
          retire    = 1'b1;
          state_nxt = S_FETCH;
        end
      end
      S_EXEC:   state_nxt = S_ALUWB;
      S_ALUWB:  begin retire = 1'b1; state_nxt = S_FETCH; end
      S_MEMADR: state_nxt = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD: begin
        dmem_req = 1'b1;
        if (dmem_ack) state_nxt = S_MEMWB;
      end
      S_MEMWB:  begin retire = 1'b1; state_nxt = S_FETCH; end
      S_MEMWR: begin
        dmem_req = 1'b1;
        dmem_we  = 1'b1;
        if (dmem_ack) begin
          retire    = 1'b1;
          state_nxt = S_FETCH;
        end
      end
      S_ADDIEX: state_nxt = S_ADDIWB;
      S_ADDIWB: begin retire = 1'b1; state_nxt = S_FETCH; end
      S_BRANCH: begin retire = 1'b1; state_nxt = S_FETCH; end
      S_JUMP:   begin retire = 1'b1; state_nxt = S_FETCH; end
      default:  state_nxt = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc      <= RESET_PC;
      ir      <= '0;
      a_reg   <= '0;
      b_reg   <= '0;
      alu_out <= '0;
      mdr     <= '0;
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else begin
      case (state)
        S_FETCH: begin
          if (imem_ack) begin
            ir <= imem_rdata;
            pc <= pc + ADDR_W'(4);
          end
        end
        S_DECODE: begin
          a_reg   <= rf[rs];
          b_reg   <= rf[rt];
          alu_out <= 32'(br_tgt);
        end
        S_EXEC, S_MEMADR, S_ADDIEX: alu_out <= alu_res;
        S_MEMRD:  if (dmem_ack) mdr <= dmem_rdata;
        S_BRANCH: if (take) pc <= ADDR_W'(alu_out);
        S_JUMP:   pc <= jmp_tgt;
        default:  ;
      endcase
      // $0 is never written, so it always reads back as zero.
      if (wr_en && (wr_addr != 5'd0)) rf[wr_addr] <= wr_data;
    end
  end

endmodule

// File: tb/tb_mips_multicycle.sv
// Self-checking bench for mips_multicycle: behavioural imem/dmem responders with programmable wait
// states feed observation queues that each scenario task compares against its own expected queues.
module tb_mips_multicycle;

  localparam int             AW  = 32;
  localparam logic [AW-1:0]  RPC = '0;

  localparam logic [5:0] OP_J = 6'h02, OP_BEQ = 6'h04, OP_ADDI = 6'h08, OP_ORI = 6'h0D;
  localparam logic [5:0] OP_LW = 6'h23, OP_SW = 6'h2B;
  localparam logic [5:0] FN_ADD = 6'h20, FN_SUB = 6'h22, FN_AND = 6'h24, FN_OR = 6'h25, FN_SLT = 6'h2A;

  logic          clk, rst;
  logic          imem_req, imem_ack, dmem_req, dmem_we, dmem_ack, retire, illegal;
  logic [AW-1:0] imem_addr, dmem_addr;
  logic [31:0]   imem_rdata, dmem_wdata, dmem_rdata;

  int checks = 0, failures = 0;
  int i_wait = 0, d_wait = 0, cyc = 0, viol = 0;

  logic [31:0] imem [256];
  logic [31:0] dmem [256];
  int          ret_obs[$], ill_obs[$], exp_ret[$], exp_ill[$];
  logic [31:0] fetch_obs[$], exp_fetch[$];
  logic [63:0] st_obs[$], exp_st[$];

  mips_multicycle #(.ADDR_W(AW), .RESET_PC(RPC)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .retire(retire), .illegal(illegal)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    if (rst) cyc++;
  end

  function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd, input logic [5:0] fn);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'h00, fn};
  endfunction
  function automatic logic [31:0] enc_i(input logic [5:0] op, input int rs, input int rt, input logic [15:0] imm);
    return {op, 5'(rs), 5'(rt), imm};
  endfunction
  function automatic logic [31:0] park();
    return {OP_BEQ, 5'd0, 5'd0, 16'hFFFF};
  endfunction

  // Memory responders plus handshake-stability and retire/illegal monitors, all sampled at negedge.
  initial begin : mem_model
    bit ip, dp;
    logic [31:0] ip_addr;
    logic [64:0] dp_val;
    int iw, dw;
    imem_ack = 0; imem_rdata = 0; dmem_ack = 0; dmem_rdata = 0;
    ip = 0; dp = 0; iw = 0; dw = 0; ip_addr = 0; dp_val = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        ip = 0; dp = 0; iw = 0; dw = 0; imem_ack = 0; dmem_ack = 0;
      end else begin
        if (ip && (!imem_req || imem_addr !== ip_addr)) viol++;
        if (dp && (!dmem_req || {dmem_we, dmem_addr, dmem_wdata} !== dp_val)) viol++;
        if (imem_req && dmem_req) viol++;
        imem_ack = 0;
        if (imem_req) begin
          if (iw >= i_wait) begin
            imem_ack = 1; imem_rdata = imem[imem_addr[9:2]]; fetch_obs.push_back(imem_addr); iw = 0;
          end else iw++;
        end else iw = 0;
        dmem_ack = 0;
        if (dmem_req) begin
          if (dw >= d_wait) begin
            dmem_ack = 1; dw = 0;
            if (dmem_we) begin
              dmem[dmem_addr[9:2]] = dmem_wdata;
              st_obs.push_back({dmem_addr, dmem_wdata});
            end else dmem_rdata = dmem[dmem_addr[9:2]];
          end else dw++;
        end else dw = 0;
        ip = imem_req && !imem_ack; ip_addr = imem_addr;
        dp = dmem_req && !dmem_ack; dp_val = {dmem_we, dmem_addr, dmem_wdata};
        #1;
        if (retire)  ret_obs.push_back(cyc);
        if (illegal) ill_obs.push_back(cyc);
      end
    end
  end

  task automatic reset_on();
    @(posedge clk);
    #1 rst = 1'b0;
    for (int k = 0; k < 256; k++) begin imem[k] = park(); dmem[k] = '0; end
  endtask

  task automatic reset_off();
    repeat (3) @(posedge clk);
    ret_obs.delete(); ill_obs.delete(); fetch_obs.delete(); st_obs.delete();
    viol = 0;
    #1 rst = 1'b1;
    cyc = 1;
  endtask

  task automatic run_until(input int n, input int limit, output bit to);
    to = 1'b1;
    for (int k = 0; k < limit; k++) begin
      @(negedge clk); #2;
      if (ret_obs.size() >= n) begin to = 1'b0; break; end
    end
  endtask

  task automatic test_reset();
    reset_on();
    imem[0] = enc_i(OP_ADDI, 0, 1, 16'd1);
    repeat (2) @(negedge clk);
    checks++;
    if ({imem_req, dmem_req, dmem_we, retire, illegal} !== 5'b0 || imem_addr !== RPC ||
        dmem_addr !== '0 || dmem_wdata !== '0) begin
      failures++;
      $display("FAIL rst_outputs got req=%b dreq=%b we=%b ret=%b ill=%b daddr=%h wdata=%h exp all 0",
               imem_req, dmem_req, dmem_we, retire, illegal, dmem_addr, dmem_wdata);
    end
    reset_off();
    @(negedge clk);
    checks++;
    if (imem_req !== 1'b1) begin failures++; $display("FAIL rst_first_req got=%b exp=1", imem_req); end
    checks++;
    if (imem_addr !== RPC) begin failures++; $display("FAIL rst_first_addr got=%h exp=%h", imem_addr, RPC); end
  endtask

  task automatic test_zero_wait();
    int e, o; logic [63:0] es, os; logic [31:0] ef, ob; bit to;
    reset_on(); i_wait = 0; d_wait = 0;
    imem[0] = enc_i(OP_ADDI, 0, 1, 16'd5);
    imem[1] = enc_i(OP_ADDI, 0, 2, 16'd7);
    imem[2] = enc_r(1, 2, 3, FN_ADD);
    imem[3] = enc_i(OP_SW, 0, 3, 16'd8);
    imem[4] = enc_i(OP_LW, 0, 4, 16'd8);
    imem[5] = enc_i(OP_SW, 0, 4, 16'd12);
    reset_off();
    exp_ret = '{4, 8, 12, 16, 21, 25};
    exp_st  = '{{32'd8, 32'd12}, {32'd12, 32'd12}};
    for (int k = 0; k < 6; k++) exp_fetch.push_back(32'(4 * k));
    run_until(exp_ret.size(), 200, to);
    checks++;
    if (to) begin failures++; $display("FAIL zw_timeout retired=%0d exp=%0d", ret_obs.size(), exp_ret.size()); end
    while (exp_ret.size() != 0) begin
      e = exp_ret.pop_front(); o = (ret_obs.size() != 0) ? ret_obs.pop_front() : -1;
      checks++; if (o !== e) begin failures++; $display("FAIL zw_retire_cycle got=%0d exp=%0d", o, e); end
    end
    while (exp_st.size() != 0) begin
      es = exp_st.pop_front(); os = (st_obs.size() != 0) ? st_obs.pop_front() : 'x;
      checks++; if (os !== es) begin failures++; $display("FAIL zw_store got=%h exp=%h", os, es); end
    end
    while (exp_fetch.size() != 0) begin
      ef = exp_fetch.pop_front(); ob = (fetch_obs.size() != 0) ? fetch_obs.pop_front() : 'x;
      checks++; if (ob !== ef) begin failures++; $display("FAIL zw_fetch_addr got=%h exp=%h", ob, ef); end
    end
    checks++;
    if (st_obs.size() != 0) begin failures++; $display("FAIL zw_extra_store got=%0d exp=0", st_obs.size()); end
  endtask

  task automatic test_alu();
    logic [63:0] es, os; logic [31:0] x, y; int e, o; bit to;
    reset_on(); i_wait = 0; d_wait = 0;
    x = 32'hFFFF_FFFD; y = 32'd5;
    imem[0]  = enc_i(OP_ADDI, 0, 1, 16'hFFFD);
    imem[1]  = enc_i(OP_ADDI, 0, 2, 16'd5);
    imem[2]  = enc_r(1, 2, 3, FN_SUB);
    imem[3]  = enc_r(1, 2, 4, FN_AND);
    imem[4]  = enc_r(1, 2, 5, FN_OR);
    imem[5]  = enc_r(1, 2, 6, FN_SLT);
    imem[6]  = enc_r(2, 1, 7, FN_SLT);
    imem[7]  = enc_r(1, 2, 0, FN_ADD);
    imem[8]  = enc_i(OP_SW, 0, 3, 16'd0);
    imem[9]  = enc_i(OP_SW, 0, 4, 16'd4);
    imem[10] = enc_i(OP_SW, 0, 5, 16'd8);
    imem[11] = enc_i(OP_SW, 0, 6, 16'd12);
    imem[12] = enc_i(OP_SW, 0, 7, 16'd16);
    imem[13] = enc_i(OP_SW, 0, 0, 16'd20);
    imem[14] = enc_i(OP_SW, 0, 2, 16'h0103);
    imem[15] = enc_i(OP_SW, 1, 2, 16'hFFFC);
    reset_off();
    for (int k = 1; k <= 16; k++) exp_ret.push_back(4 * k);
    exp_st = '{{32'd0, x - y}, {32'd4, x & y}, {32'd8, x | y}, {32'd12, 32'd1}, {32'd16, 32'd0},
               {32'd20, 32'd0}, {32'h103, y}, {x - 32'd4, y}};
    run_until(exp_ret.size(), 300, to);
    checks++;
    if (to) begin failures++; $display("FAIL alu_timeout retired=%0d exp=%0d", ret_obs.size(), exp_ret.size()); end
    while (exp_ret.size() != 0) begin
      e = exp_ret.pop_front(); o = (ret_obs.size() != 0) ? ret_obs.pop_front() : -1;
      checks++; if (o !== e) begin failures++; $display("FAIL alu_retire_cycle got=%0d exp=%0d", o, e); end
    end
    while (exp_st.size() != 0) begin
      es = exp_st.pop_front(); os = (st_obs.size() != 0) ? st_obs.pop_front() : 'x;
      checks++; if (os !== es) begin failures++; $display("FAIL alu_store got=%h exp=%h", os, es); end
    end
  endtask

  task automatic test_wait_states();
    int e, o; logic [63:0] es, os; bit to;
    reset_on(); i_wait = 3; d_wait = 2;
    imem[0] = enc_i(OP_ADDI, 0, 1, 16'h0055);
    imem[1] = enc_i(OP_SW, 0, 1, 16'h0020);
    imem[2] = enc_i(OP_LW, 0, 2, 16'h0020);
    imem[3] = enc_i(OP_SW, 0, 2, 16'h0024);
    reset_off();
    exp_ret = '{7, 16, 26, 35};
    exp_st  = '{{32'h20, 32'h55}, {32'h24, 32'h55}};
    run_until(exp_ret.size(), 300, to);
    checks++;
    if (to) begin failures++; $display("FAIL ws_timeout retired=%0d exp=%0d", ret_obs.size(), exp_ret.size()); end
    while (exp_ret.size() != 0) begin
      e = exp_ret.pop_front(); o = (ret_obs.size() != 0) ? ret_obs.pop_front() : -1;
      checks++; if (o !== e) begin failures++; $display("FAIL ws_retire_cycle got=%0d exp=%0d", o, e); end
    end
    while (exp_st.size() != 0) begin
      es = exp_st.pop_front(); os = (st_obs.size() != 0) ? st_obs.pop_front() : 'x;
      checks++; if (os !== es) begin failures++; $display("FAIL ws_store got=%h exp=%h", os, es); end
    end
    checks++;
    if (viol != 0) begin failures++; $display("FAIL ws_handshake_stable violations=%0d exp=0", viol); end
    i_wait = 0; d_wait = 0;
  endtask

  task automatic test_branch();
    int e, o; logic [63:0] es, os; logic [31:0] ef, ob; bit to;
    reset_on(); i_wait = 0; d_wait = 0;
    imem[0]  = enc_i(OP_ADDI, 0, 1, 16'd1);
    imem[1]  = enc_i(OP_ADDI, 0, 2, 16'd2);
    imem[2]  = enc_i(OP_BEQ, 1, 2, 16'd5);
    imem[3]  = {OP_J, 26'h000_0010};
    imem[4]  = enc_i(OP_SW, 0, 1, 16'h0080);
    imem[16] = enc_i(OP_BEQ, 1, 1, 16'd1);
    imem[17] = enc_i(OP_SW, 0, 1, 16'h0088);
    imem[18] = enc_i(OP_SW, 0, 2, 16'h0084);
    imem[19] = enc_i(OP_BEQ, 1, 1, 16'hFFFF);
    reset_off();
    exp_ret   = '{4, 8, 11, 14, 17, 21, 24, 27, 30};
    exp_fetch = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h40, 32'h48, 32'h4C, 32'h4C, 32'h4C};
    exp_st    = '{{32'h84, 32'd2}};
    run_until(exp_ret.size(), 300, to);
    checks++;
    if (to) begin failures++; $display("FAIL br_timeout retired=%0d exp=%0d", ret_obs.size(), exp_ret.size()); end
    while (exp_ret.size() != 0) begin
      e = exp_ret.pop_front(); o = (ret_obs.size() != 0) ? ret_obs.pop_front() : -1;
      checks++; if (o !== e) begin failures++; $display("FAIL br_retire_cycle got=%0d exp=%0d", o, e); end
    end
    while (exp_fetch.size() != 0) begin
      ef = exp_fetch.pop_front(); ob = (fetch_obs.size() != 0) ? fetch_obs.pop_front() : 'x;
      checks++; if (ob !== ef) begin failures++; $display("FAIL br_fetch_addr got=%h exp=%h", ob, ef); end
    end
    while (exp_st.size() != 0) begin
      es = exp_st.pop_front(); os = (st_obs.size() != 0) ? st_obs.pop_front() : 'x;
      checks++; if (os !== es) begin failures++; $display("FAIL br_store got=%h exp=%h", os, es); end
    end
    checks++;
    if (st_obs.size() != 0) begin failures++; $display("FAIL br_extra_store got=%0d exp=0", st_obs.size()); end
  endtask

  task automatic test_illegal();
    int e, o; logic [63:0] es, os; logic [31:0] ef, ob; bit to;
    reset_on(); i_wait = 0; d_wait = 0;
    imem[0] = enc_i(OP_ADDI, 0, 1, 16'd9);
    imem[1] = {6'h3F, 5'd0, 5'd1, 16'h0004};
    imem[2] = enc_r(1, 1, 1, 6'h3F);
    imem[3] = enc_i(OP_ORI, 0, 5, 16'hFFFF);
    imem[4] = enc_i(OP_SW, 0, 1, 16'd0);
    imem[5] = enc_i(OP_SW, 0, 5, 16'd4);
    reset_off();
`ifdef MIPS_EXT_ISA_EN
    exp_ret = '{4, 6, 8, 12, 16, 20};
    exp_ill = '{6, 8};
    exp_st  = '{{32'd0, 32'd9}, {32'd4, 32'h0000_FFFF}};
`else
    exp_ret = '{4, 6, 8, 10, 14, 18};
    exp_ill = '{6, 8, 10};
    exp_st  = '{{32'd0, 32'd9}, {32'd4, 32'd0}};
`endif
    for (int k = 0; k < 6; k++) exp_fetch.push_back(32'(4 * k));
    run_until(exp_ret.size(), 200, to);
    checks++;
    if (to) begin failures++; $display("FAIL ill_timeout retired=%0d exp=%0d", ret_obs.size(), exp_ret.size()); end
    while (exp_ret.size() != 0) begin
      e = exp_ret.pop_front(); o = (ret_obs.size() != 0) ? ret_obs.pop_front() : -1;
      checks++; if (o !== e) begin failures++; $display("FAIL ill_retire_cycle got=%0d exp=%0d", o, e); end
    end
    while (exp_ill.size() != 0) begin
      e = exp_ill.pop_front(); o = (ill_obs.size() != 0) ? ill_obs.pop_front() : -1;
      checks++; if (o !== e) begin failures++; $display("FAIL ill_pulse_cycle got=%0d exp=%0d", o, e); end
    end
    checks++;
    if (ill_obs.size() != 0) begin failures++; $display("FAIL ill_extra_pulse got=%0d exp=0", ill_obs.size()); end
    while (exp_st.size() != 0) begin
      es = exp_st.pop_front(); os = (st_obs.size() != 0) ? st_obs.pop_front() : 'x;
      checks++; if (os !== es) begin failures++; $display("FAIL ill_store got=%h exp=%h", os, es); end
    end
    while (exp_fetch.size() != 0) begin
      ef = exp_fetch.pop_front(); ob = (fetch_obs.size() != 0) ? fetch_obs.pop_front() : 'x;
      checks++; if (ob !== ef) begin failures++; $display("FAIL ill_fetch_addr got=%h exp=%h", ob, ef); end
    end
  endtask

  task automatic test_reset_mid();
    logic [63:0] es, os; logic [31:0] ob; bit seen, to;
    reset_on(); i_wait = 0; d_wait = 6;
    imem[0] = enc_i(OP_ADDI, 0, 1, 16'd7);
    imem[1] = enc_i(OP_LW, 0, 2, 16'd0);
    reset_off();
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk); #2;
      if (dmem_req) begin seen = 1'b1; break; end
    end
    checks++;
    if (!seen) begin failures++; $display("FAIL rm_memrd_timeout dmem_req=%b exp=1", dmem_req); end
    rst = 1'b0;
    #1;
    checks++;
    if (dmem_req !== 1'b0) begin failures++; $display("FAIL rm_dmem_req_drop got=%b exp=0", dmem_req); end
    checks++;
    if (imem_req !== 1'b0) begin failures++; $display("FAIL rm_imem_req_low got=%b exp=0", imem_req); end
    d_wait = 0;
    imem[0] = enc_i(OP_SW, 0, 1, 16'h0010);
    imem[1] = park();
    reset_off();
    exp_ret = '{4};
    exp_st  = '{{32'h10, 32'd0}};
    run_until(exp_ret.size(), 100, to);
    checks++;
    if (to) begin failures++; $display("FAIL rm_timeout retired=%0d exp=1", ret_obs.size()); end
    ob = (fetch_obs.size() != 0) ? fetch_obs.pop_front() : 'x;
    checks++;
    if (ob !== RPC) begin failures++; $display("FAIL rm_restart_pc got=%h exp=%h", ob, RPC); end
    while (exp_st.size() != 0) begin
      es = exp_st.pop_front(); os = (st_obs.size() != 0) ? st_obs.pop_front() : 'x;
      checks++; if (os !== es) begin failures++; $display("FAIL rm_reg_cleared_store got=%h exp=%h", os, es); end
    end
    exp_ret.delete();
  endtask

  initial begin
    rst = 1'b0;
    test_reset();
    test_zero_wait();
    test_alu();
    test_wait_states();
    test_branch();
    test_illegal();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
